// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    // Loader FSM states.
    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StCheck,
        StDone,
        StErr
    } state_e;

    // Failure causes reported on err_code.
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/byte_to_word_packer.sv
// Assembles four big-endian bytes into one 32-bit word.
module byte_to_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [23:0] shift_q;
    logic [1:0]  cnt_q;

    // The fourth byte completes the word combinationally; the owner registers it.
    always_comb begin
        word_valid_o = byte_valid_i && (cnt_q == 2'd3);
        word_o       = {shift_q, byte_i};
    end

    // Shift accepted bytes in MSB first and count them modulo 4.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (byte_valid_i) begin
            shift_q <= {shift_q[15:0], byte_i};
            cnt_q   <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checked program image from a byte stream into
// instruction memory while holding the CPU in reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned MAX_WORDS      = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [15:0] words_loaded
);

    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic [7:0]  csum_q, csum_d;
    logic [31:0] tmo_q, tmo_d;
    logic [1:0]  err_q, err_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        accept;
    logic        pack_clear;
    logic        pk_valid;
    logic [31:0] pk_word;
    logic [15:0] len_full;

    assign accept   = rx_valid && rx_ready;
    assign len_full = {len_q[15:8], rx_data};

    byte_to_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (pack_clear),
        .byte_valid_i (accept && (state_q == StData)),
        .byte_i       (rx_data),
        .word_valid_o (pk_valid),
        .word_o       (pk_word)
    );

    // Status outputs decode directly from the current state.
    always_comb begin
        rx_ready     = (state_q == StLenHi) || (state_q == StLenLo) ||
                       (state_q == StData)  || (state_q == StCheck);
        busy         = rx_ready;
        // ERR keeps the CPU held so a partial image never runs.
        cpu_hold     = rx_ready || (state_q == StErr);
        done         = (state_q == StDone);
        error        = (state_q == StErr);
        err_code     = err_q;
        words_loaded = wcnt_q;
        mem_we       = we_q;
        mem_addr     = addr_q;
        mem_wdata    = wdata_q;
    end

    // Next-state, checksum, timeout and memory-write logic.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wcnt_d     = wcnt_q;
        csum_d     = csum_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        pack_clear = 1'b0;

        if (rx_ready) begin
            tmo_d = accept ? 32'd0 : tmo_q + 32'd1;
        end
        if (accept && (state_q != StCheck)) begin
            csum_d = csum_q ^ rx_data;
        end
        if (pk_valid) begin
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + {14'd0, wcnt_q, 2'b00};
            wdata_d = pk_word;
            wcnt_d  = wcnt_q + 16'd1;
        end

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d    = StLenHi;
                    csum_d     = '0;
                    wcnt_d     = '0;
                    err_d      = ERR_NONE;
                    tmo_d      = '0;
                    pack_clear = 1'b1;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d   = {rx_data, 8'h00};
                    state_d = StLenLo;
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_d = len_full;
                    if ({16'd0, len_full} > MAX_WORDS) begin
                        state_d = StErr;
                        err_d   = ERR_LEN;
                    end else if (len_full == 16'd0) begin
                        state_d = StCheck;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (pk_valid && (wcnt_q == len_q - 16'd1)) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (accept) begin
                    if (rx_data == csum_q) begin
                        state_d = StDone;
                    end else begin
                        state_d = StErr;
                        err_d   = ERR_CSUM;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Stalled stream: abort after TIMEOUT_CYCLES cycles without an accepted byte.
        if (rx_ready && !accept && (tmo_q == TIMEOUT_CYCLES - 1)) begin
            state_d = StErr;
            err_d   = ERR_TIMEOUT;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            wcnt_q  <= '0;
            csum_q  <= '0;
            tmo_q   <= '0;
            err_q   <= ERR_NONE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            csum_q  <= csum_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a program image as a byte stream (e.g. from a UART receiver) and writes 32-bit instruction words into the instruction memory's write port.
- Holds the processor in reset while loading, then releases it.
- Validates the image length and an XOR checksum.
- Sits between the serial byte receiver and instruction memory, beside the CPU reset logic.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- MAX_WORDS, 256, largest accepted image in words; larger lengths are rejected.
- TIMEOUT_CYCLES, 1_000_000, idle cycles between accepted bytes before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a load
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction memory write enable (one-cycle pulse)
- mem_addr  out  32  byte address of the word being written
- mem_wdata  out  32  instruction word
- cpu_hold  out  1  keeps the CPU in reset
- busy  out  1  load in progress
- done  out  1  last load succeeded (sticky)
- error  out  1  last load failed (sticky)
- err_code  out  2  01 length>MAX_WORDS, 10 checksum mismatch, 11 timeout
- words_loaded  out  16  words written in current or last load

Behaviour:
- Reset
  - One clock; reset is synchronous and active-high.
  - State IDLE; all outputs 0, including cpu_hold, so the CPU runs the existing memory image.
- Byte transfer
  - A byte is accepted only on a cycle with rx_valid & rx_ready.
  - rx_ready=1 in LEN_HI, LEN_LO, DATA and CHECK; 0 elsewhere.
- Stream format, all big-endian: 2-byte word count N, then 4·N bytes (MSB of each word first), then 1 checksum byte.
  - The checksum byte must equal the XOR of all preceding bytes, including the length bytes.
- States
  - IDLE/DONE/ERR: start → LEN_HI. In the same cycle set busy=1 and cpu_hold=1, clear done/error/err_code/words_loaded/checksum, and set the word index to 0.
  - LEN_HI → LEN_LO on accept.
  - LEN_LO on accept:
    - N>MAX_WORDS → ERR, code 01.
    - N=0 → CHECK.
    - Otherwise → DATA.
  - DATA: shift bytes into a 32-bit assembler.
    - On the 4th accepted byte, the next cycle drives mem_we=1, mem_addr=BASE_ADDR+4·index, mem_wdata=assembled word.
    - index and words_loaded increment by 1 in that same cycle.
    - rx_ready stays 1 during the write pulse (no stall).
    - After the write of word N-1 → CHECK.
  - CHECK on accept:
    - Byte equals the running XOR → DONE: done=1, busy=0, cpu_hold=0 in the following cycle.
    - Otherwise → ERR, code 10.
  - ERR: busy=0, error=1; cpu_hold stays 1 so a partial image never executes. Only start or rst leaves ERR.
- Timeout
  - The counter resets on every accepted byte and on entering LEN_HI.
  - It counts in LEN_HI/LEN_LO/DATA/CHECK.
  - Reaching TIMEOUT_CYCLES → ERR, code 11.
- start while busy=1 is ignored.
- rst mid-load returns to IDLE immediately with cpu_hold=0; memory contents already written are left as-is.
- mem_addr arithmetic is 32-bit unsigned and wraps modulo 2^32.
- mem_addr/mem_wdata hold their last values when mem_we=0.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum (IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR)
  - err_code localparams ERR_NONE=2'b00, ERR_LEN=2'b01, ERR_CSUM=2'b10, ERR_TIMEOUT=2'b11
- One natural sub-module: byte_to_word_packer.
  - Function: 4-byte shift register plus a 2-bit byte counter.
  - Outputs: word_valid pulse and word.
  - Clear input: driven when a load starts.
- FSM, address/index counter, checksum and timeout stay in imem_loader.

Test Plan:
- Normal load
  - Stimulus: start, then bytes 00 02 E2 80 00 02 E2 80 10 05 15 with rx_valid held high.
  - Required: writes (addr 0x0, data E2800002) then (0x4, E2801005); words_loaded=2; done=1; cpu_hold falls one cycle after the checksum byte is accepted.
- Bad checksum
  - Stimulus: same stream with final byte 14.
  - Required: both writes occur; error=1; err_code=10; cpu_hold remains 1; done=0.
- Oversize length
  - Stimulus: MAX_WORDS=256, length bytes 01 01 (N=257).
  - Required: ERR with err_code=01 right after LEN_LO; no mem_we pulse ever.
- Zero-length image
  - Stimulus: bytes 00 00 00.
  - Required: done=1; words_loaded=0; no mem_we pulse.
- Timeout and reset
  - Timeout: TIMEOUT_CYCLES=16; send 00 01 E2 then stop. Required: error=1 and err_code=11 exactly 16 idle cycles after the E2 byte.
  - Restart: a new start followed by a valid stream succeeds.
  - Reset mid-load: rst asserted during DATA returns all outputs to 0 on the next edge.
- Back-pressure, start while busy, and wrap-around
  - Back-pressure: rx_valid toggles randomly. Required: identical writes to the normal-load scenario.
  - Start while busy: a start pulse mid-load is ignored; the image completes unchanged.
  - Wrap-around: BASE_ADDR=32'hFFFF_FFFC with a 2-word image writes 0xFFFFFFFC then 0x0.
